// File: rtl/counter_tx_pkg.sv
// Shared types and constants for the counter snapshot transmitter.
package counter_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    C0,
    C1
  } state_t;

  localparam logic [7:0] HDR_TAG  = 8'hA5;
  localparam int         SEQ_W    = 8;
  localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/counter_snapshot_tx.sv
// Captures both 64-bit event counters on a snapshot request and streams them
// as a framed sequence of WORD_W-bit words: header, Count0 LSW-first, then
// Count1 LSW-first. Valid/ready handshake; all outputs registered.
module counter_snapshot_tx
  import counter_tx_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Snap,
  input  logic [63:0]       Count0,
  input  logic [63:0]       Count1,
  output logic [WORD_W-1:0] TxData,
  output logic              TxValid,
  input  logic              TxReady,
  output logic              TxLast,
  output logic              Busy,
  output logic [7:0]        DropCnt
);

  // Words per captured counter (4, 2 or 1); a 2-bit index covers all cases.
  localparam int             WPC      = 64 / WORD_W;
  localparam logic [1:0]     IDX_LAST = 2'(WPC - 1);

  if (WORD_W != 16 && WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("counter_snapshot_tx: WORD_W must be 16, 32 or 64");
  end

  state_t             r_state, w_state_n;
  logic [1:0]         r_idx, w_idx_n;
  logic [127:0]       r_cap;
  logic [SEQ_W-1:0]   r_seq;
  logic [7:0]         r_drop;
  logic [WORD_W-1:0]  r_data, w_data_n;
  logic               r_valid, r_last, r_busy;
  logic               w_last_n;
  logic               w_hs, w_accept, w_drop, w_word_last;
  logic [6:0]         w_lsb;
  logic [WORD_W-1:0]  w_word, w_hdr;

  assign w_hs        = r_valid && TxReady;
  assign w_word_last = (r_idx == IDX_LAST);

  // Next-state / word-index logic; a request is accepted from IDLE or on the
  // final handshake of a frame, otherwise it counts as dropped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_accept  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Snap) begin
          w_state_n = HDR;
          w_accept  = 1'b1;
        end
      end
      HDR: begin
        if (w_hs) begin
          w_state_n = C0;
          w_idx_n   = '0;
        end
      end
      C0: begin
        if (w_hs) begin
          if (w_word_last) begin
            w_state_n = C1;
            w_idx_n   = '0;
          end else begin
            w_idx_n = r_idx + 2'd1;
          end
        end
      end
      C1: begin
        if (w_hs) begin
          if (w_word_last) begin
            w_idx_n = '0;
            if (Snap) begin
              w_state_n = HDR;
              w_accept  = 1'b1;
            end else begin
              w_state_n = IDLE;
            end
          end else begin
            w_idx_n = r_idx + 2'd1;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
    w_drop = Snap && !w_accept && (r_state != IDLE);
  end

  // Word to present next: header on acceptance, otherwise the captured word
  // picked by the next state/index; held unchanged while the sink stalls.
  always_comb begin
    w_lsb    = 7'((((w_state_n == C1) ? WPC : 0) + int'(w_idx_n)) * WORD_W);
    w_word   = r_cap[w_lsb +: WORD_W];
    w_hdr    = {HDR_TAG, (WORD_W - 8)'(r_seq)};
    w_data_n = r_data;
    if (w_accept) begin
      w_data_n = w_hdr;
    end else if (w_state_n == IDLE) begin
      w_data_n = '0;
    end else if (w_hs) begin
      w_data_n = w_word;
    end
    w_last_n = (w_state_n == C1) && (w_idx_n == IDX_LAST);
  end

  // Control and output registers, synchronous active-high reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_seq   <= '0;
      r_drop  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_data  <= w_data_n;
      r_last  <= w_last_n;
      r_valid <= (w_state_n != IDLE);
      r_busy  <= (w_state_n != IDLE);
      if (w_accept) begin
        r_seq <= r_seq + 1'b1;
      end
      if (w_drop && r_drop != DROP_MAX) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  // Snapshot register, loaded only on an accepted request.
  always_ff @(posedge Clk) begin
    // NOTE: pure datapath storage is not reset; it is always loaded before
    // any beat that reads it becomes valid.
    if (w_accept) begin
      r_cap <= {Count1, Count0};
    end
  end

  assign TxData  = r_data;
  assign TxValid = r_valid;
  assign TxLast  = r_last;
  assign Busy    = r_busy;
  assign DropCnt = r_drop;

endmodule

// File: tb/tb_counter_snapshot_tx.sv
// Scoreboard bench for counter_snapshot_tx at WORD_W = 16.
`timescale 1ns/1ps
module tb_counter_snapshot_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        snap;
  logic [63:0] count0, count1;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready, tx_last, busy;
  logic [7:0]  drop_cnt;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;

  counter_snapshot_tx #(.WORD_W(16)) dut (
    .Clk(clk), .Reset(rst), .Snap(snap), .Count0(count0), .Count1(count1),
    .TxData(tx_data), .TxValid(tx_valid), .TxReady(tx_ready),
    .TxLast(tx_last), .Busy(busy), .DropCnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] seq, input logic [63:0] c0, input logic [63:0] c1);
    beat_t b;
    b.data = {8'hA5, seq};
    b.last = 1'b0;
    exp_q.push_back(b);
    for (int i = 0; i < 4; i++) begin
      b.data = c0[16*i +: 16];
      exp_q.push_back(b);
    end
    for (int i = 0; i < 4; i++) begin
      b.data = c1[16*i +: 16];
      b.last = (i == 3);
      exp_q.push_back(b);
    end
  endtask

  // Counts sampled cycles with Busy high until the frame ends.
  task automatic run_until_idle(input bit inc, output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      if (inc) begin
        count0 = count0 + 64'd1;
        count1 = count1 + 64'd1;
      end
      tick();
    end
    if (busy) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, expected 0", busy, cycles);
    end
  endtask

  task automatic wait_last();
    int n = 0;
    while (!tx_last && n < 20) begin
      n++;
      tick();
    end
    if (!tx_last) begin
      n_chk++;
      n_err++;
      $display("FAIL last_timeout: TxLast %b after %0d cycles, expected 1", tx_last, n);
    end
  endtask

  // Monitor: each handshake pops one expected beat and compares it.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_beat: got %h, expected no beat", tx_data);
        end else begin
          b = exp_q.pop_front();
          check("beat_data", tx_data, b.data);
          check("beat_last", tx_last, b.last);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [63:0] c0_a = 64'h0123_4567_89AB_CDEF;
    logic [63:0] c1_a = 64'h0000_0000_0000_0005;
    logic [63:0] c0_b = 64'h1111_2222_3333_4444;
    logic [63:0] c1_b = 64'hFFFF_FFFF_FFFF_FFFE;
    logic [63:0] c0_c = 64'hDEAD_BEEF_0BAD_F00D;
    logic [63:0] c1_c = 64'h8000_0000_0000_0001;

    rst = 1'b1; snap = 1'b0; tx_ready = 1'b1; count0 = '0; count1 = '0;
    tick(); tick();
    check("rst_valid", tx_valid, 0);
    check("rst_busy",  busy, 0);
    check("rst_last",  tx_last, 0);
    check("rst_data",  tx_data, 0);
    check("rst_drop",  drop_cnt, 0);
    rst = 1'b0;
    tick();

    // 1: single frame, sink always ready.
    count0 = c0_a; count1 = c1_a;
    push_frame(8'h00, c0_a, c1_a);
    snap = 1'b1; tick(); snap = 1'b0;
    check("s1_first_valid", tx_valid, 1);
    check("s1_first_hdr", tx_data, 16'hA500);
    run_until_idle(0, cyc);
    check("s1_busy_cycles", cyc, 9);
    check("s1_queue_empty", exp_q.size(), 0);
    tick();

    // 2: three stall cycles on the 89AB beat.
    push_frame(8'h01, c0_a, c1_a);
    snap = 1'b1; tick(); snap = 1'b0;
    tick(); tick();
    check("s2_stall_data0", tx_data, 16'h89AB);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s2_stall_valid", tx_valid, 1);
      check("s2_stall_data", tx_data, 16'h89AB);
    end
    tx_ready = 1'b1;
    run_until_idle(0, cyc);
    check("s2_frame_cycles", cyc + 5, 12);
    check("s2_queue_empty", exp_q.size(), 0);
    tick();

    // 3: counters keep moving after capture.
    count0 = c0_b; count1 = c1_b;
    push_frame(8'h02, c0_b, c1_b);
    snap = 1'b1; tick(); snap = 1'b0;
    run_until_idle(1, cyc);
    check("s3_busy_cycles", cyc, 9);
    check("s3_queue_empty", exp_q.size(), 0);
    tick();

    // 4: dropped request mid-frame, then accepted on the final handshake.
    count0 = c0_a; count1 = c1_a;
    push_frame(8'h03, c0_a, c1_a);
    snap = 1'b1; tick(); snap = 1'b0;
    tick(); tick(); tick();
    check("s4_beat4", tx_data, 16'h4567);
    snap = 1'b1; tick(); snap = 1'b0;
    check("s4_drop_one", drop_cnt, 1);
    wait_last();
    push_frame(8'h04, c0_a, c1_a);
    snap = 1'b1; tick(); snap = 1'b0;
    check("s4_b2b_valid", tx_valid, 1);
    check("s4_b2b_hdr", tx_data, 16'hA504);
    check("s4_drop_kept", drop_cnt, 1);
    run_until_idle(0, cyc);
    check("s4_queue_empty", exp_q.size(), 0);

    // 5: 257 back-to-back frames from reset, Snap held high throughout.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    count0 = c0_c; count1 = c1_c;
    push_frame(8'h00, c0_c, c1_c);
    snap = 1'b1; tick();
    for (int k = 1; k <= 256; k++) begin
      logic [7:0] s;
      s = 8'(k);
      wait_last();
      push_frame(s, c0_c, c1_c);
      tick();
      check("s5_b2b_valid", tx_valid, 1);
      check("s5_hdr", tx_data, {8'hA5, s});
    end
    snap = 1'b0;
    run_until_idle(0, cyc);
    check("s5_drop_sat", drop_cnt, 8'hFF);
    check("s5_queue_empty", exp_q.size(), 0);
    tick();

    // 6: reset during beat 5 aborts the frame.
    count0 = c0_a; count1 = c1_a;
    push_frame(8'h01, c0_a, c1_a);
    snap = 1'b1; tick(); snap = 1'b0;
    tick(); tick(); tick(); tick();
    check("s6_beat5", tx_data, 16'h0123);
    rst = 1'b1; tick();
    check("s6_rst_valid", tx_valid, 0);
    check("s6_rst_busy",  busy, 0);
    check("s6_rst_drop",  drop_cnt, 0);
    check("s6_rst_last",  tx_last, 0);
    exp_q.delete();
    rst = 1'b0;
    tick();
    check("s6_idle_valid", tx_valid, 0);
    push_frame(8'h00, c0_a, c1_a);
    snap = 1'b1; tick(); snap = 1'b0;
    check("s6_hdr", tx_data, 16'hA500);
    run_until_idle(0, cyc);
    check("s6_busy_cycles", cyc, 9);
    check("s6_queue_empty", exp_q.size(), 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
